// File: rtl/jpeg_dec_pkg.sv
// Shared encodings for the JPEG MCU scheduler: FSM states, component codes, table selects.
// The RESTART state only exists when JPEG_MCU_SCHED_RESTART_EN is defined.
package jpeg_dec_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StNext  = 3'd4,
        StDone  = 3'd5
`ifdef JPEG_MCU_SCHED_RESTART_EN
        , StRestart = 3'd6
`endif
    } sched_state_e;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam logic TBL_LUMA   = 1'b0;
    localparam logic TBL_CHROMA = 1'b1;

    // Luma blocks come first in an MCU, then one Cb and one Cr block.
    function automatic logic [1:0] comp_of_block(input logic [2:0] idx, input logic [2:0] idx_cb);
        if (idx < idx_cb) begin
            return COMP_Y;
        end else if (idx == idx_cb) begin
            return COMP_CB;
        end
        return COMP_CR;
    endfunction

endpackage

// File: rtl/jpeg_mcu_sched_if.sv
// Block-request handshake between the MCU scheduler (master) and the
// entropy/IDQ/IDCT datapath (slave).
interface jpeg_mcu_sched_if #(
    parameter int unsigned DIM_W = 12
);
    logic             BlockReady;
    logic             BlockDone;
    logic             BlockStart;
    logic [2:0]       BlockIndex;
    logic [1:0]       BlockComp;
    logic             DqtSel;
    logic             HuffSel;
    logic [DIM_W-1:0] McuX;
    logic [DIM_W-1:0] McuY;
    logic             PredClear;

    modport master (
        input  BlockReady, BlockDone,
        output BlockStart, BlockIndex, BlockComp, DqtSel, HuffSel, McuX, McuY, PredClear
    );

    modport slave (
        output BlockReady, BlockDone,
        input  BlockStart, BlockIndex, BlockComp, DqtSel, HuffSel, McuX, McuY, PredClear
    );
endinterface

// File: rtl/jpeg_mcu_counter.sv
// MCU X/Y position counter: X wraps at width-1 and carries into Y; last_o marks the
// final MCU of the image.
module jpeg_mcu_counter #(
    parameter int unsigned DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [DIM_W-1:0] x_o,
    output logic [DIM_W-1:0] y_o,
    output logic             last_o
);
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic             x_wrap;

    assign x_wrap = (x_q == width_i - DIM_W'(1));
    assign last_o = x_wrap && (y_q == height_i - DIM_W'(1));
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
            end else begin
                x_d = x_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/jpeg_mcu_sched.sv
// MCU/block scheduler for the JPEG decode datapath: walks the image MCU by MCU and issues
// one 8x8 block request at a time. JPEG_MCU_SCHED_RESTART_EN adds restart-interval handling.
module jpeg_mcu_sched
    import jpeg_dec_pkg::*;
#(
    parameter int unsigned LUMA_BLOCKS = 4,
    parameter int unsigned DIM_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ImageEnable,
    input  logic [DIM_W-1:0] McuWidth,
    input  logic [DIM_W-1:0] McuHeight,
`ifdef JPEG_MCU_SCHED_RESTART_EN
    input  logic [15:0]      RestartInterval,
    output logic             RstReq,
    input  logic             RstAck,
`endif
    output logic             ImageEnd,
    output logic             Busy,
    jpeg_mcu_sched_if.master blk
);
    localparam logic [2:0] IdxCb   = 3'(LUMA_BLOCKS);
    localparam logic [2:0] IdxLast = 3'(LUMA_BLOCKS + 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic             ended_q, ended_d;
    logic             cnt_clr, cnt_inc, mcu_last;
    logic             start, pclr, img_end;
`ifdef JPEG_MCU_SCHED_RESTART_EN
    logic [15:0]      rst_cnt_q, rst_cnt_d;
    logic             rst_req;
`endif

    jpeg_mcu_counter #(
        .DIM_W(DIM_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .width_i (width_q),
        .height_i(height_q),
        .x_o     (blk.McuX),
        .y_o     (blk.McuY),
        .last_o  (mcu_last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        width_d  = width_q;
        height_d = height_q;
        ended_d  = (state_q == StDone);
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        start    = 1'b0;
        pclr     = 1'b0;
        img_end  = 1'b0;
`ifdef JPEG_MCU_SCHED_RESTART_EN
        rst_cnt_d = rst_cnt_q;
        rst_req   = 1'b0;
`endif
        // Dropping ImageEnable aborts from any state and suppresses every pulse.
        if (state_q != StIdle && !ImageEnable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_clr = 1'b1;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            rst_cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: if (ImageEnable) state_d = StInit;
                StInit: begin
                    idx_d    = '0;
                    cnt_clr  = 1'b1;
                    pclr     = 1'b1;
                    width_d  = McuWidth;
                    height_d = McuHeight;
`ifdef JPEG_MCU_SCHED_RESTART_EN
                    rst_cnt_d = '0;
`endif
                    state_d = (McuWidth == '0 || McuHeight == '0) ? StDone : StIssue;
                end
                StIssue: begin
                    if (blk.BlockReady) begin
                        start   = 1'b1;
                        state_d = StWait;
                    end
                end
                StWait: if (blk.BlockDone) state_d = StNext;
                StNext: begin
                    if (idx_q < IdxLast) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StIssue;
                    end else begin
                        idx_d   = '0;
                        cnt_inc = 1'b1;
`ifdef JPEG_MCU_SCHED_RESTART_EN
                        rst_cnt_d = rst_cnt_q + 16'd1;
`endif
                        if (mcu_last) begin
                            state_d = StDone;
`ifdef JPEG_MCU_SCHED_RESTART_EN
                        end else if (RestartInterval != '0 &&
                                     rst_cnt_q + 16'd1 == RestartInterval) begin
                            state_d = StRestart;
`endif
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end
                StDone: img_end = !ended_q;
`ifdef JPEG_MCU_SCHED_RESTART_EN
                StRestart: begin
                    rst_req = 1'b1;
                    if (RstAck) begin
                        pclr      = 1'b1;
                        rst_cnt_d = '0;
                        state_d   = StIssue;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            ended_q  <= 1'b0;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            rst_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            width_q  <= width_d;
            height_q <= height_d;
            ended_q  <= ended_d;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            rst_cnt_q <= rst_cnt_d;
`endif
        end
    end

    assign blk.BlockStart = start;
    assign blk.BlockIndex = idx_q;
    assign blk.BlockComp  = comp_of_block(idx_q, IdxCb);
    assign blk.DqtSel     = (idx_q >= IdxCb) ? TBL_CHROMA : TBL_LUMA;
    assign blk.HuffSel    = (idx_q >= IdxCb) ? TBL_CHROMA : TBL_LUMA;
    assign blk.PredClear  = pclr;
    assign ImageEnd       = img_end;
    assign Busy           = (state_q != StIdle);
`ifdef JPEG_MCU_SCHED_RESTART_EN
    assign RstReq         = rst_req;
`endif
endmodule

// File: tb/tb_jpeg_mcu_sched.sv
// Scoreboard bench for jpeg_mcu_sched: a reference walk of the image fills an expected-block
// queue, a negedge monitor pops and compares on every BlockStart.
module tb_jpeg_mcu_sched;
    localparam int LB  = 4;
    localparam int BPM = LB + 2;

    typedef struct packed {
        logic [2:0]  idx;
        logic [1:0]  comp;
        logic        dqt;
        logic        huff;
        logic [11:0] x;
        logic [11:0] y;
    } ent_t;

    logic        clk, rst, ImageEnable, ImageEnd, Busy;
    logic [11:0] McuWidth, McuHeight;
`ifdef JPEG_MCU_SCHED_RESTART_EN
    logic [15:0] RestartInterval;
    logic        RstReq, RstAck;
`endif

    jpeg_mcu_sched_if #(.DIM_W(12)) blk ();

    jpeg_mcu_sched #(
        .LUMA_BLOCKS(LB),
        .DIM_W      (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ImageEnable    (ImageEnable),
        .McuWidth       (McuWidth),
        .McuHeight      (McuHeight),
`ifdef JPEG_MCU_SCHED_RESTART_EN
        .RestartInterval(RestartInterval),
        .RstReq         (RstReq),
        .RstAck         (RstAck),
`endif
        .ImageEnd       (ImageEnd),
        .Busy           (Busy),
        .blk            (blk)
    );

    ent_t exp_q[$];
    int   rst_exp_q[$];
    int   n_chk = 0, n_err = 0;
    int   n_start = 0, n_end = 0, n_pc = 0, n_rq = 0;
    int   fixed_dly = 3;
    bit   rand_ready = 0, ready_lvl = 1;
    int   glitch_req = 0, glitch_ack = 0;
    bit   outstanding = 0, rq_prev = 0;
    int   b_start, b_end, b_pc, b_rq, b_nrst, b_blocks;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Datapath stand-in: answers each BlockStart with a BlockDone after a delay, and acks
    // restart requests four cycles after they appear.
    initial begin
        bit st_seen, rq_seen, pend;
        int cnt, rq_cnt;
        blk.BlockReady = 0;
        blk.BlockDone  = 0;
        pend = 0; cnt = 0; rq_cnt = 0; rq_seen = 0;
`ifdef JPEG_MCU_SCHED_RESTART_EN
        RstAck = 0;
`endif
        forever begin
            @(negedge clk);
            st_seen = blk.BlockStart;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            rq_seen = RstReq;
`endif
            @(posedge clk);
            #1;
            blk.BlockDone = 0;
            if (st_seen) begin
                pend = 1;
                cnt  = (fixed_dly != 0) ? fixed_dly - 1 : int'($urandom_range(0, 3));
            end
            if (pend) begin
                if (cnt == 0) begin
                    blk.BlockDone = 1;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            blk.BlockReady = rand_ready ? ($urandom_range(0, 3) != 0) : ready_lvl;
            if (blk.BlockReady && glitch_req != glitch_ack) begin
                blk.BlockDone = 1;
                glitch_ack++;
            end
            rq_cnt = rq_seen ? rq_cnt + 1 : 0;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            RstAck = (rq_cnt == 4);
`endif
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        ent_t got, exp_e;
        int   exp_r;
        if (!rst) begin
            if (blk.BlockDone) outstanding = 0;
            if (!Busy) outstanding = 0;
            if (blk.BlockStart) begin
                n_start++;
                chk("start_while_outstanding", outstanding, 0);
                outstanding = 1;
                got   = {blk.BlockIndex, blk.BlockComp, blk.DqtSel, blk.HuffSel,
                         blk.McuX, blk.McuY};
                exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk("block_fields", got, exp_e);
            end
            if (blk.PredClear) n_pc++;
            if (ImageEnd) n_end++;
`ifdef JPEG_MCU_SCHED_RESTART_EN
            if (RstReq && !rq_prev) begin
                n_rq++;
                exp_r = (rst_exp_q.size() != 0) ? rst_exp_q.pop_front() : -1;
                chk("rstreq_remaining_blocks", exp_q.size(), exp_r);
            end
            rq_prev = RstReq;
`endif
        end
    end

    // Reference walk: row-major MCUs, luma blocks then Cb then Cr inside each MCU.
    task automatic push_model(input int w, input int h, input int intv);
        ent_t e;
        int   total = w * h;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                for (int b = 0; b < BPM; b++) begin
                    e.idx  = 3'(b);
                    e.comp = (b < LB) ? 2'd0 : 2'(b - LB + 1);
                    e.dqt  = (b >= LB);
                    e.huff = (b >= LB);
                    e.x    = 12'(x);
                    e.y    = 12'(y);
                    exp_q.push_back(e);
                end
        b_nrst = 0;
        if (intv != 0)
            for (int m = intv; m < total; m += intv) begin
                rst_exp_q.push_back((total - m) * BPM);
                b_nrst++;
            end
        b_blocks = total * BPM;
    endtask

    task automatic start_image(input int w, input int h, input int intv, input bit scramble);
        b_start = n_start; b_end = n_end; b_pc = n_pc; b_rq = n_rq;
        push_model(w, h, intv);
        @(posedge clk);
        #1;
        McuWidth  = 12'(w);
        McuHeight = 12'(h);
`ifdef JPEG_MCU_SCHED_RESTART_EN
        RestartInterval = 16'(intv);
`endif
        ImageEnable = 1;
        if (scramble) begin
            repeat (2) @(posedge clk);
            #1;
            McuWidth  = 12'($urandom_range(1, 9));
            McuHeight = 12'($urandom_range(1, 9));
        end
    endtask

    task automatic finish_image();
        int budget = 5000;
        while (n_end == b_end && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        chk("busy_in_done", Busy, 1);
        @(posedge clk);
        #1 ImageEnable = 0;
        repeat (2) @(negedge clk);
        chk("busy_after_image", Busy, 0);
        chk("image_end_count", n_end - b_end, 1);
        chk("pred_clear_count", n_pc - b_pc, 1 + b_nrst);
        chk("block_start_count", n_start - b_start, b_blocks);
        chk("leftover_blocks", exp_q.size(), 0);
`ifdef JPEG_MCU_SCHED_RESTART_EN
        chk("rstreq_count", n_rq - b_rq, b_nrst);
        chk("leftover_restarts", rst_exp_q.size(), 0);
`endif
        exp_q.delete();
        rst_exp_q.delete();
    endtask

    initial begin
        int budget, w, h, intv;
        rst = 1; ImageEnable = 0; McuWidth = 0; McuHeight = 0;
`ifdef JPEG_MCU_SCHED_RESTART_EN
        RestartInterval = 0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {blk.BlockStart, blk.BlockIndex, blk.BlockComp, blk.DqtSel,
            blk.HuffSel, blk.McuX, blk.McuY, blk.PredClear, ImageEnd, Busy}, 0);
        @(posedge clk);
        #1 rst = 0;

        // 2x1 image, always ready, done three cycles after each start.
        start_image(2, 1, 0, 0);
        finish_image();

        // BlockReady held low in ISSUE, then released with a BlockDone in the same cycle.
        ready_lvl = 0;
        start_image(1, 1, 0, 0);
        repeat (12) @(negedge clk);
        chk("ready_low_no_start", n_start - b_start, 0);
        glitch_req++;
        ready_lvl = 1;
        @(negedge clk);
        chk("start_on_first_ready", blk.BlockStart, 1);
        finish_image();

        // Zero-width image: INIT then DONE, ImageEnd two cycles after enable.
        start_image(0, 5, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("zero_init_pred_clear", blk.PredClear, 1);
        @(negedge clk);
        chk("zero_done_image_end", ImageEnd, 1);
        finish_image();

        // Abort in WAIT of MCU (1,0), then re-assert for a full image.
        fixed_dly = 5;
        start_image(3, 2, 0, 0);
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        budget = 500;
        while (n_start - b_start < 7 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk);
        #1 ImageEnable = 0;
        @(negedge clk);
        chk("abort_no_start", blk.BlockStart, 0);
        @(negedge clk);
        chk("abort_idle", Busy, 0);
        chk("abort_cleared_pos", {blk.McuX, blk.McuY, blk.BlockIndex}, 0);
        repeat (8) @(negedge clk);
        chk("abort_no_image_end", n_end - b_end, 0);
        chk("abort_blocks_issued", n_start - b_start, 7);
        exp_q.delete();
        fixed_dly = 3;
        start_image(3, 2, 0, 0);
        finish_image();

`ifdef JPEG_MCU_SCHED_RESTART_EN
        // Restart every 2 MCUs on a 3x1 image: one request, after MCU 1 only.
        fixed_dly = 2;
        start_image(3, 1, 2, 0);
        finish_image();
`endif

        // Randomised images with random ready/done timing and late dimension changes.
        fixed_dly = 0;
        rand_ready = 1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
`ifdef JPEG_MCU_SCHED_RESTART_EN
            intv = $urandom_range(0, 3);
`else
            intv = 0;
`endif
            start_image(w, h, intv, 1);
            finish_image();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/jpeg_mcu_sched.md
Name: jpeg_mcu_sched

Overview:
Block-level scheduler for the JPEG entropy/IDQ/IDCT datapath once the marker FSM enters image-data mode. Walks the image MCU by MCU and issues one 8x8 block decode request at a time. For each request it provides the component ID, quantiser table select and Huffman table select. It tracks MCU X/Y position, pulses DC-predictor clears and flags end of image.

Parameters:
LUMA_BLOCKS, 4, luma blocks per MCU (legal 1, 2, 4); blocks per MCU = LUMA_BLOCKS+2
DIM_W, 12, width of MCU dimension/position fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ImageEnable  in  1  level; high while the marker FSM is in image-data state
McuWidth  in  DIM_W  image width in MCUs (from SOF0 block width)
McuHeight  in  DIM_W  image height in MCUs
BlockReady  in  1  datapath can accept a new block
BlockDone  in  1  1-cycle pulse, current block fully decoded
BlockStart  out  1  1-cycle pulse, launch one block decode
BlockIndex  out  3  block number within MCU, 0..LUMA_BLOCKS+1
BlockComp  out  2  0=Y, 1=Cb, 2=Cr
DqtSel  out  1  0 luma table, 1 chroma table
HuffSel  out  1  0 DC0/AC0, 1 DC1/AC1
McuX  out  DIM_W  current MCU column
McuY  out  DIM_W  current MCU row
PredClear  out  1  1-cycle pulse, clear DC predictors of all components
ImageEnd  out  1  1-cycle pulse, last block of image done
Busy  out  1  scheduler not in IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, INIT, ISSUE, WAIT, NEXT, DONE (+RESTART with option).
- IDLE: ImageEnable=1 -> INIT.
- INIT (1 cycle): BlockIndex, McuX and McuY cleared; PredClear=1. If McuWidth==0 or McuHeight==0 -> DONE, else -> ISSUE.
- ISSUE: waits for BlockReady=1. BlockStart=1 for exactly that cycle, then -> WAIT. Minimum latency INIT to BlockStart is 1 cycle.
- WAIT: BlockDone sampled only here; a BlockDone seen in any other state is ignored. BlockDone -> NEXT.
- NEXT (1 cycle), in order:
  - If BlockIndex<LUMA_BLOCKS+1: BlockIndex+1 -> ISSUE.
  - Else BlockIndex=0 and McuX+1.
  - If McuX==McuWidth-1: McuX=0 and McuY+1.
  - If McuY==McuHeight-1 at that wrap -> DONE, else -> ISSUE.
- DONE (1 cycle): ImageEnd=1. Then IDLE once ImageEnable=0; stays in DONE (ImageEnd not repeated) while ImageEnable remains 1.
- Mapping, combinational from BlockIndex:
  - Index < LUMA_BLOCKS: BlockComp=0, DqtSel=0, HuffSel=0.
  - Index == LUMA_BLOCKS: Comp=1, DqtSel=1, HuffSel=1.
  - Index == LUMA_BLOCKS+1: Comp=2, DqtSel=1, HuffSel=1.
- BlockIndex/BlockComp/DqtSel/HuffSel/McuX/McuY are stable from BlockStart until NEXT.
- Abort: ImageEnable=0 in any state other than IDLE -> IDLE next cycle. Counters cleared, no ImageEnd, no BlockStart that cycle.
- Busy = (state != IDLE).
- McuWidth/McuHeight are sampled only in INIT into internal registers; later input changes are ignored until the next image.

Optional Feature:
Macro JPEG_MCU_SCHED_RESTART_EN.
- When defined, adds ports:
  - RestartInterval in 16: MCUs per interval, 0 = disabled.
  - RstReq out 1.
  - RstAck in 1.
- A 16-bit MCU counter increments at each MCU completion in NEXT. When it reaches RestartInterval and the image is not finished, go to RESTART instead of ISSUE.
- RESTART: RstReq=1 held until RstAck=1. Then PredClear 1-cycle pulse, counter cleared, -> ISSUE.
- The last MCU of the image never triggers RESTART.
- Without the macro: no ports, no RESTART state; PredClear pulses only in INIT.

Decomposition:
- Package jpeg_dec_pkg holds:
  - state encoding constants.
  - component codes COMP_Y=0, COMP_CB=1, COMP_CR=2.
  - table select constants TBL_LUMA=0, TBL_CHROMA=1.
- Sub-module jpeg_mcu_counter: X/Y wrap counter with clear and inc, plus a last-MCU flag. The scheduler instantiates it once.

Test Plan:
- McuWidth=2, McuHeight=1, BlockReady tied 1, BlockDone 3 cycles after each BlockStart -> 12 BlockStarts; BlockComp sequence 0,0,0,0,1,2 twice; McuX 0 then 1; one ImageEnd after the 12th BlockDone; one PredClear.
- BlockReady held 0 for 10 cycles in ISSUE -> no BlockStart; BlockStart appears in the first cycle BlockReady=1.
- McuWidth=0, McuHeight=5 -> INIT, DONE, ImageEnd after 2 cycles, zero BlockStarts.
- ImageEnable dropped in WAIT of MCU (1,0) -> IDLE next cycle, no ImageEnd. Re-assert -> restarts at McuX=0, McuY=0, BlockIndex=0.
- BlockDone pulsed in the same cycle as BlockStart -> ignored; state stays WAIT until the next BlockDone.
- Restart option: RestartInterval=2, image 3x1 MCUs, RstAck 4 cycles after RstReq -> exactly one RstReq after MCU 1; PredClear pulses in INIT and after the ack; no RstReq after the last MCU.
